// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for the 5-stage MIPS core. Generates the hold
// (stall) and bubble (flush) controls for the PC, IF/ID, ID/EX, EX/MEM and
// MEM/WB registers from the current pipeline contents, and keeps a mul/div
// busy tracker plus two saturating performance counters.
//
// Parameters:
//   REG_W         register-address width
//   BRANCH_IN_EX  1: branches resolve in EX (flush IF/ID and ID/EX)
//                 0: branches resolve in ID (flush IF/ID only, with an
//                    operand interlock on the branch sources)
//   MD_LATENCY    mul/div busy cycles (0 = no mul/div unit)
//   CNT_W         performance counter width
//
// Ports:
//   clk, reset_n                      clock (rising edge), async active-low reset
//   if_id_rs/rt, id_uses_rs/rt        source registers of the ID instruction
//   id_is_branch, id_md_use           ID instruction class
//   id_ex_rt, id_ex_mem_read          load in EX (load-use detection)
//   id_ex_wreg, id_ex_reg_write       destination of the EX instruction
//   ex_mem_wreg, ex_mem_mem_read      load in MEM (ID branch interlock)
//   md_start                          EX instruction launches mul/div
//   mem_wait                          data memory not ready: freeze pipeline
//   jump, branch_taken                control-flow change requests
//   cnt_clr                           synchronous clear of both counters
//   pc_stall .. ex_mem_stall          hold the register
//   if_id_flush .. mem_wb_flush       load a bubble
//   md_busy                           mul/div unit occupied
//   stall_count, flush_count          saturating event counters
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_W        = 5,
    parameter int BRANCH_IN_EX = 1,
    parameter int MD_LATENCY   = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             id_md_use,
    input  logic [REG_W-1:0] id_ex_rt,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_wreg,
    input  logic             id_ex_reg_write,
    input  logic [REG_W-1:0] ex_mem_wreg,
    input  logic             ex_mem_mem_read,
    input  logic             md_start,
    input  logic             mem_wait,
    input  logic             jump,
    input  logic             branch_taken,
    input  logic             cnt_clr,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic BR_EX = (BRANCH_IN_EX != 0);
    // A zero-latency unit still needs a 1-bit counter; it simply never loads
    // a nonzero value, so md_busy stays low.
    localparam int MD_W = (MD_LATENCY > 0) ? $clog2(MD_LATENCY + 1) : 1;
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LATENCY);

    logic            freeze;
    logic            lu;
    logic            mdh;
    logic            brh;
    logic            brx;
    logic            hz;
    logic            rs_br_dep;
    logic            rt_br_dep;
    logic [MD_W-1:0] md_cnt;

    // -------------------------------------------------------------------------
    // Hazard terms
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in this always_comb gets a value on entry,
    // so no path can leave one unassigned and infer a latch.
    always_comb begin
        lu        = 1'b0;
        rs_br_dep = 1'b0;
        rt_br_dep = 1'b0;
        brh       = 1'b0;

        freeze = mem_wait;

        // Load in EX whose result the ID instruction needs next cycle.
        if (id_ex_mem_read && (id_ex_rt != '0)) begin
            lu = (id_uses_rs && (id_ex_rt == if_id_rs)) ||
                 (id_uses_rt && (id_ex_rt == if_id_rt));
        end

        mdh = id_md_use && md_busy;

        // An ID-resolved branch compares its operands in ID, so it must wait
        // for any ALU result still in EX and any load result still in MEM.
        rs_br_dep = id_uses_rs && (if_id_rs != '0) &&
                    ((id_ex_reg_write && (id_ex_wreg == if_id_rs)) ||
                     (ex_mem_mem_read && (ex_mem_wreg == if_id_rs)));
        rt_br_dep = id_uses_rt && (if_id_rt != '0) &&
                    ((id_ex_reg_write && (id_ex_wreg == if_id_rt)) ||
                     (ex_mem_mem_read && (ex_mem_wreg == if_id_rt)));
        brh = !BR_EX && id_is_branch && (rs_br_dep || rt_br_dep);

        brx = BR_EX && branch_taken;

        // A taken branch resolved in EX squashes the ID instruction, so there
        // is nothing left to stall for.
        hz = (lu || mdh || brh) && !brx;
    end

    // -------------------------------------------------------------------------
    // Stall / flush outputs (zero latency)
    // -------------------------------------------------------------------------
    assign pc_stall     = freeze | hz;
    assign if_id_stall  = freeze | hz;
    assign id_ex_stall  = freeze;
    assign ex_mem_stall = freeze;
    assign mem_wb_flush = freeze;

    // A jump or ID-resolved branch seen while ID is stalled is not lost: its
    // inputs stay asserted and the flush fires once the stall clears.
    assign if_id_flush  = !freeze && (brx || (!hz && (jump || (!BR_EX && branch_taken))));
    assign id_ex_flush  = !freeze && (hz || brx);

    // -------------------------------------------------------------------------
    // Mul/div busy tracker
    // -------------------------------------------------------------------------
    assign md_busy = (md_cnt != '0);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt <= '0;
        end else if (md_start && !freeze && !md_busy) begin
            md_cnt <= MD_LOAD;
        end else if (md_busy) begin
            // Keeps counting through a memory freeze: the unit runs on its own.
            md_cnt <= md_cnt - MD_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Saturating performance counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else if (cnt_clr) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (pc_stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (if_id_flush && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Scoreboard bench for hazard_ctrl. Two instances share the same inputs:
//   dut_a: BRANCH_IN_EX=1, MD_LATENCY=4, CNT_W=4
//   dut_b: BRANCH_IN_EX=0, MD_LATENCY=4, CNT_W=4
// The driver applies directed vectors just after each rising edge and pushes
// a hand-computed expected output word into a queue; the monitor pops and
// compares on the falling edge.
//
// Expected word layout (16 bits):
//   [15] pc_stall  [14] if_id_stall  [13] id_ex_stall  [12] ex_mem_stall
//   [11] if_id_flush  [10] id_ex_flush  [9] mem_wb_flush  [8] md_busy
//   [7:4] stall_count  [3:0] flush_count
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam logic [15:0] M_CTL = 16'hFE00;
    localparam logic [15:0] M_MD  = 16'h0100;
    localparam logic [15:0] M_ALL = 16'hFFFF;

    typedef struct {
        string       name;
        bit          sel_b;
        logic [15:0] exp;
        logic [15:0] mask;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] if_id_rs, if_id_rt, id_ex_rt, id_ex_wreg, ex_mem_wreg;
    logic       id_uses_rs, id_uses_rt, id_is_branch, id_md_use;
    logic       id_ex_mem_read, id_ex_reg_write, ex_mem_mem_read;
    logic       md_start, mem_wait, jump, branch_taken, cnt_clr;

    logic       a_pc_stall, a_if_id_stall, a_id_ex_stall, a_ex_mem_stall;
    logic       a_if_id_flush, a_id_ex_flush, a_mem_wb_flush, a_md_busy;
    logic [3:0] a_stall_count, a_flush_count;
    logic       b_pc_stall, b_if_id_stall, b_id_ex_stall, b_ex_mem_stall;
    logic       b_if_id_flush, b_id_ex_flush, b_mem_wb_flush, b_md_busy;
    logic [3:0] b_stall_count, b_flush_count;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(5), .BRANCH_IN_EX(1), .MD_LATENCY(4), .CNT_W(4)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .id_md_use(id_md_use),
        .id_ex_rt(id_ex_rt), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_wreg(id_ex_wreg), .id_ex_reg_write(id_ex_reg_write),
        .ex_mem_wreg(ex_mem_wreg), .ex_mem_mem_read(ex_mem_mem_read),
        .md_start(md_start), .mem_wait(mem_wait), .jump(jump),
        .branch_taken(branch_taken), .cnt_clr(cnt_clr),
        .pc_stall(a_pc_stall), .if_id_stall(a_if_id_stall),
        .id_ex_stall(a_id_ex_stall), .ex_mem_stall(a_ex_mem_stall),
        .if_id_flush(a_if_id_flush), .id_ex_flush(a_id_ex_flush),
        .mem_wb_flush(a_mem_wb_flush), .md_busy(a_md_busy),
        .stall_count(a_stall_count), .flush_count(a_flush_count)
    );

    hazard_ctrl #(.REG_W(5), .BRANCH_IN_EX(0), .MD_LATENCY(4), .CNT_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .id_md_use(id_md_use),
        .id_ex_rt(id_ex_rt), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_wreg(id_ex_wreg), .id_ex_reg_write(id_ex_reg_write),
        .ex_mem_wreg(ex_mem_wreg), .ex_mem_mem_read(ex_mem_mem_read),
        .md_start(md_start), .mem_wait(mem_wait), .jump(jump),
        .branch_taken(branch_taken), .cnt_clr(cnt_clr),
        .pc_stall(b_pc_stall), .if_id_stall(b_if_id_stall),
        .id_ex_stall(b_id_ex_stall), .ex_mem_stall(b_ex_mem_stall),
        .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush),
        .mem_wb_flush(b_mem_wb_flush), .md_busy(b_md_busy),
        .stall_count(b_stall_count), .flush_count(b_flush_count)
    );

    logic [15:0] act_a, act_b;
    assign act_a = {a_pc_stall, a_if_id_stall, a_id_ex_stall, a_ex_mem_stall,
                    a_if_id_flush, a_id_ex_flush, a_mem_wb_flush, a_md_busy,
                    a_stall_count, a_flush_count};
    assign act_b = {b_pc_stall, b_if_id_stall, b_id_ex_stall, b_ex_mem_stall,
                    b_if_id_flush, b_id_ex_flush, b_mem_wb_flush, b_md_busy,
                    b_stall_count, b_flush_count};

    // -------------------------------------------------------------------------
    // Monitor: compares every pending expectation on the falling edge
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [15:0] act;
            e   = q.pop_front();
            act = e.sel_b ? act_b : act_a;
            n_cmp++;
            if ((act & e.mask) !== (e.exp & e.mask)) begin
                n_err++;
                $display("FAIL %s (%s): got %h expected %h (mask %h)",
                         e.name, e.sel_b ? "dut_b" : "dut_a",
                         act & e.mask, e.exp & e.mask, e.mask);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver helpers
    // -------------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input bit sel_b,
                        input logic [15:0] exp, input logic [15:0] mask);
        exp_t e;
        e.name  = name;
        e.sel_b = sel_b;
        e.exp   = exp;
        e.mask  = mask;
        q.push_back(e);
    endtask

    task automatic clear_in();
        if_id_rs = '0; if_id_rt = '0; id_ex_rt = '0; id_ex_wreg = '0;
        ex_mem_wreg = '0;
        id_uses_rs = 0; id_uses_rt = 0; id_is_branch = 0; id_md_use = 0;
        id_ex_mem_read = 0; id_ex_reg_write = 0; ex_mem_mem_read = 0;
        md_start = 0; mem_wait = 0; jump = 0; branch_taken = 0; cnt_clr = 0;
    endtask

    task automatic load_use();
        id_ex_mem_read = 1; id_ex_rt = 5'd8; if_id_rs = 5'd8; id_uses_rs = 1;
    endtask

    // -------------------------------------------------------------------------
    // Directed stimulus
    // -------------------------------------------------------------------------
    initial begin
        reset_n = 1'b0;
        clear_in();

        // Reset state
        cyc();
        push("reset_state", 0, 16'h0000, M_ALL);
        push("reset_state", 1, 16'h0000, M_ALL);
        cyc(); reset_n = 1'b1;

        // Load-use
        cyc(); clear_in(); load_use();
        push("load_use_rs", 0, 16'hC400, M_CTL);
        cyc(); clear_in(); load_use(); id_ex_rt = 5'd0; if_id_rs = 5'd0;
        push("load_use_r0", 0, 16'h0000, M_CTL);
        cyc(); clear_in(); id_ex_mem_read = 1; id_ex_rt = 5'd5; if_id_rt = 5'd5;
        id_uses_rt = 1; jump = 1;
        push("load_use_rt_jump", 0, 16'hC400, M_CTL);
        cyc(); clear_in(); jump = 1;
        push("jump_after_stall", 0, 16'h0800, M_CTL);
        cyc(); clear_in(); id_ex_mem_read = 1; id_ex_rt = 5'd5; if_id_rt = 5'd5;
        push("load_rt_unused", 0, 16'h0000, M_CTL);

        // Mul/div tracker: start sampled at end of cycle S
        cyc(); clear_in(); md_start = 1;
        push("md_s0", 0, 16'h0000, M_CTL | M_MD);
        cyc(); clear_in();
        push("md_s1", 0, 16'h0100, M_CTL | M_MD);
        cyc(); clear_in(); md_start = 1; id_md_use = 1;
        push("md_s2_use_stall", 0, 16'hC500, M_CTL | M_MD);
        cyc(); clear_in();
        push("md_s3", 0, 16'h0100, M_CTL | M_MD);
        cyc(); clear_in();
        push("md_s4", 0, 16'h0100, M_CTL | M_MD);
        cyc(); clear_in(); id_md_use = 1;
        push("md_s5_no_stall", 0, 16'h0000, M_CTL | M_MD);
        cyc(); clear_in();
        push("md_s6_restart_ignored", 0, 16'h0000, M_CTL | M_MD);
        cyc(); clear_in(); md_start = 1; mem_wait = 1;
        push("md_start_frozen", 0, 16'hF200, M_CTL | M_MD);
        cyc(); clear_in();
        push("md_not_loaded", 0, 16'h0000, M_CTL | M_MD);

        // Memory freeze with a pending EX branch
        for (int i = 0; i < 3; i++) begin
            cyc(); clear_in(); mem_wait = 1; branch_taken = 1;
            push("freeze_branch", 0, 16'hF200, M_CTL);
        end
        cyc(); clear_in(); branch_taken = 1;
        push("freeze_release", 0, 16'h0C00, M_CTL);
        cyc(); clear_in(); load_use(); mem_wait = 1;
        push("freeze_masks_lu", 0, 16'hF200, M_CTL);
        cyc(); clear_in(); load_use(); branch_taken = 1;
        push("brx_cancels_lu", 0, 16'h0C00, M_CTL);

        // Branch resolved in ID (dut_b) versus EX (dut_a)
        cyc(); clear_in(); id_is_branch = 1; if_id_rs = 5'd9; id_uses_rs = 1;
        id_ex_wreg = 5'd9; id_ex_reg_write = 1;
        push("brh_ex_alu", 1, 16'hC400, M_CTL);
        push("no_brh_in_ex_cfg", 0, 16'h0000, M_CTL);
        cyc(); clear_in(); id_is_branch = 1; if_id_rs = 5'd9; id_uses_rs = 1;
        ex_mem_wreg = 5'd9; ex_mem_mem_read = 1;
        push("brh_mem_load", 1, 16'hC400, M_CTL);
        cyc(); clear_in(); id_is_branch = 1; if_id_rs = 5'd9; id_uses_rs = 1;
        ex_mem_wreg = 5'd9; branch_taken = 1;
        push("id_branch_taken", 1, 16'h0800, M_CTL);
        push("ex_branch_taken", 0, 16'h0C00, M_CTL);
        cyc(); clear_in(); id_is_branch = 1; id_uses_rs = 1; id_ex_reg_write = 1;
        push("brh_r0", 1, 16'h0000, M_CTL);
        cyc(); clear_in(); id_is_branch = 1; if_id_rt = 5'd7; id_uses_rt = 1;
        id_ex_wreg = 5'd7; id_ex_reg_write = 1; branch_taken = 1;
        push("brh_rt_defers_flush", 1, 16'hC400, M_CTL);

        // Counters (CNT_W=4)
        cyc(); clear_in(); cnt_clr = 1;
        cyc(); clear_in();
        push("cnt_cleared", 0, 16'h0000, M_ALL);
        for (int k = 1; k <= 20; k++) begin
            logic [3:0] s;
            s = (k - 1 > 15) ? 4'd15 : 4'(k - 1);
            cyc(); clear_in(); load_use();
            push("stall_count_ramp", 0, {8'hC4, s, 4'h0}, M_ALL);
        end
        cyc(); clear_in();
        push("stall_count_sat", 0, 16'h00F0, M_ALL);
        cyc(); clear_in(); jump = 1;
        push("flush_count_0", 0, 16'h08F0, M_ALL);
        cyc(); clear_in(); jump = 1;
        push("flush_count_1", 0, 16'h08F1, M_ALL);
        cyc(); clear_in(); jump = 1;
        push("flush_count_2", 0, 16'h08F2, M_ALL);
        cyc(); clear_in();
        push("flush_count_3", 0, 16'h00F3, M_ALL);
        cyc(); clear_in(); load_use(); jump = 1; cnt_clr = 1;
        push("clr_cycle", 0, 16'hC4F3, M_ALL);
        cyc(); clear_in();
        push("clr_priority", 0, 16'h0000, M_ALL);
        cyc(); clear_in(); load_use();
        push("recount_0", 0, 16'hC400, M_ALL);
        cyc(); clear_in(); load_use();
        push("recount_1", 0, 16'hC410, M_ALL);
        cyc(); clear_in(); load_use(); md_start = 1;
        push("recount_2", 0, 16'hC420, M_ALL);

        // Asynchronous reset mid-count with mul/div busy
        cyc(); clear_in(); reset_n = 1'b0;
        push("async_reset", 0, 16'h0000, M_ALL);
        cyc(); reset_n = 1'b1;
        push("after_reset", 0, 16'h0000, M_ALL);
        cyc(); clear_in();
        push("idle", 0, 16'h0000, M_ALL);

        // Drain the scoreboard, bounded
        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
